// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line engine: FSM states, frame lengths, CRC7.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    WAIT_START,
    RX,
    NCC
  } sd_state_t;

  localparam logic [7:0] FRAME_LEN_SHORT = 8'd48;
  localparam logic [7:0] FRAME_LEN_LONG  = 8'd136;
  localparam logic [6:0] CRC7_POLY       = 7'h09;  // x^7 + x^3 + 1

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    return {crc[5:0], 1'b0} ^ (((din ^ crc[6]) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_if.sv
// Command/status bundle between the SD register block (master) and the CMD engine (slave).
interface sd_cmd_if;
  logic [5:0]  i_command_index;
  logic [31:0] i_command_argument;
  logic        i_command_long_response;
  logic        i_command_skip_response;
  logic        i_command_start;
  logic [5:0]  o_command_index;
  logic [31:0] o_command_response;
  logic        o_command_busy;
  logic        o_command_timeout;
  logic        o_command_response_crc_error;

  modport master (
    output i_command_index, i_command_argument, i_command_long_response,
           i_command_skip_response, i_command_start,
    input  o_command_index, o_command_response, o_command_busy,
           o_command_timeout, o_command_response_crc_error
  );

  modport slave (
    input  i_command_index, i_command_argument, i_command_long_response,
           i_command_skip_response, i_command_start,
    output o_command_index, o_command_response, o_command_busy,
           o_command_timeout, o_command_response_crc_error
  );
endinterface

// File: rtl/sd_crc_7.sv
// Serial CRC7 accumulator; clear and enable together restart the CRC with the current bit.
module sd_crc_7
  import sd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_data,
  output logic [6:0] o_crc
);

  logic [6:0] crc_reg;
  logic [6:0] crc_base;

  assign crc_base = i_clear ? 7'h00 : crc_reg;
  assign o_crc    = crc_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_reg <= 7'h00;
    end else if (i_enable) begin
      crc_reg <= crc7_step(crc_base, i_data);
    end else if (i_clear) begin
      crc_reg <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_cmd.sv
// SD CMD-line engine: sends a 48-bit command with CRC7 and receives/checks the response.
// Optional build macro SD_CMD_INDEX_CHECK_EN flags short responses whose index differs from the sent one.
module sd_cmd
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NCC_CYCLES     = 8
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_sd_clk_rising,
  input  logic    i_sd_clk_falling,
  output logic    o_sd_cmd_oe,
  output logic    o_sd_cmd_out,
  input  logic    i_sd_cmd_in,
  sd_cmd_if.slave cmd
);

  localparam int             WAIT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     NCC_LAST     = 8'(NCC_CYCLES - 1);

  sd_state_t          state_reg;
  logic [7:0]         bit_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [39:0]        tx_shift_reg;
  logic [38:0]        rx_shift_reg;
  logic [5:0]         rx_index_reg;
  logic               long_reg;
  logic               skip_reg;
  logic               oe_reg;
  logic               out_reg;
  logic [5:0]         index_reg;
  logic [31:0]        response_reg;
  logic               busy_reg;
  logic               timeout_reg;
  logic               crc_error_reg;
`ifdef SD_CMD_INDEX_CHECK_EN
  logic [5:0]         sent_index_reg;
`endif

  logic       rise;
  logic       fall;
  logic [7:0] frame_len;
  logic [2:0] crc_sel;
  logic       tx_bit;
  logic       rx_in_crc;
  logic       rx_error;
  logic       crc_clear;
  logic       crc_enable;
  logic       crc_data;
  logic [6:0] crc_value;

  // A simultaneous rising/falling pair is treated as a rising edge only.
  assign rise      = i_sd_clk_rising;
  assign fall      = i_sd_clk_falling && !i_sd_clk_rising;
  assign frame_len = long_reg ? FRAME_LEN_LONG : FRAME_LEN_SHORT;
  assign crc_sel   = 3'(8'd46 - bit_cnt_reg);
  assign tx_bit    = (bit_cnt_reg < 8'd40) ? tx_shift_reg[39] :
                     (bit_cnt_reg < 8'd47) ? crc_value[crc_sel] : 1'b1;
  // Long responses leave the first 8 received bits out of the CRC.
  assign rx_in_crc = (bit_cnt_reg < frame_len - 8'd8) && (!long_reg || bit_cnt_reg >= 8'd8);

`ifdef SD_CMD_INDEX_CHECK_EN
  assign rx_error = (rx_shift_reg[6:0] != crc_value) || !i_sd_cmd_in ||
                    (!long_reg && (rx_index_reg != sent_index_reg));
`else
  assign rx_error = (rx_shift_reg[6:0] != crc_value) || !i_sd_cmd_in;
`endif

  always_comb begin
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    crc_data   = 1'b0;
    case (state_reg)
      IDLE: crc_clear = cmd.i_command_start;
      TX: if (fall && bit_cnt_reg < 8'd40) begin
        crc_enable = 1'b1;
        crc_data   = tx_shift_reg[39];
      end
      WAIT_START: if (rise && !i_sd_cmd_in) begin
        crc_clear  = 1'b1;
        crc_enable = !long_reg;
      end
      RX: if (rise && rx_in_crc) begin
        crc_enable = 1'b1;
        crc_data   = i_sd_cmd_in;
      end
      default: ;
    endcase
  end

  sd_crc_7 u_crc (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (crc_clear),
    .i_enable (crc_enable),
    .i_data   (crc_data),
    .o_crc    (crc_value)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 8'd0;
      wait_cnt_reg  <= '0;
      tx_shift_reg  <= 40'd0;
      rx_shift_reg  <= 39'd0;
      rx_index_reg  <= 6'd0;
      long_reg      <= 1'b0;
      skip_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      out_reg       <= 1'b1;
      index_reg     <= 6'd0;
      response_reg  <= 32'd0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      crc_error_reg <= 1'b0;
`ifdef SD_CMD_INDEX_CHECK_EN
      sent_index_reg <= 6'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (cmd.i_command_start) begin
          tx_shift_reg  <= {2'b01, cmd.i_command_index, cmd.i_command_argument};
          long_reg      <= cmd.i_command_long_response;
          skip_reg      <= cmd.i_command_skip_response;
          timeout_reg   <= 1'b0;
          crc_error_reg <= 1'b0;
          busy_reg      <= 1'b1;
          bit_cnt_reg   <= 8'd0;
          state_reg     <= TX;
`ifdef SD_CMD_INDEX_CHECK_EN
          sent_index_reg <= cmd.i_command_index;
`endif
        end
        TX: if (fall) begin
          if (bit_cnt_reg == FRAME_LEN_SHORT) begin
            oe_reg       <= 1'b0;
            out_reg      <= 1'b1;
            bit_cnt_reg  <= 8'd0;
            wait_cnt_reg <= '0;
            state_reg    <= skip_reg ? NCC : WAIT_START;
          end else begin
            oe_reg       <= 1'b1;
            out_reg      <= tx_bit;
            tx_shift_reg <= {tx_shift_reg[38:0], 1'b0};
            bit_cnt_reg  <= bit_cnt_reg + 8'd1;
          end
        end
        WAIT_START: if (rise) begin
          if (!i_sd_cmd_in) begin
            rx_shift_reg <= 39'd0;
            bit_cnt_reg  <= 8'd1;
            state_reg    <= RX;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            timeout_reg <= 1'b1;
            bit_cnt_reg <= 8'd0;
            state_reg   <= NCC;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RX: if (rise) begin
          rx_shift_reg <= {rx_shift_reg[37:0], i_sd_cmd_in};
          bit_cnt_reg  <= bit_cnt_reg + 8'd1;
          // After 8 bits the low 6 hold the index field for either frame length.
          if (bit_cnt_reg == 8'd7) begin
            rx_index_reg <= {rx_shift_reg[4:0], i_sd_cmd_in};
          end
          if (bit_cnt_reg == frame_len - 8'd1) begin
            index_reg     <= rx_index_reg;
            response_reg  <= rx_shift_reg[38:7];
            crc_error_reg <= rx_error;
            bit_cnt_reg   <= 8'd0;
            state_reg     <= NCC;
          end
        end
        NCC: if (rise) begin
          if (bit_cnt_reg == NCC_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_sd_cmd_oe                      = oe_reg;
  assign o_sd_cmd_out                     = out_reg;
  assign cmd.o_command_index              = index_reg;
  assign cmd.o_command_response           = response_reg;
  assign cmd.o_command_busy               = busy_reg;
  assign cmd.o_command_timeout            = timeout_reg;
  assign cmd.o_command_response_crc_error = crc_error_reg;

endmodule

// File: doc/sd_cmd.md
Name: sd_cmd

Overview:
SD CMD-line engine and counterpart to the SD register block. Consumes the command fields and start pulse, serialises the 48-bit command frame with CRC7 onto CMD, then receives and checks the 48- or 136-bit response. Returns index, response word, busy, timeout and CRC-error status. Runs in the system clock domain; SD clock edges arrive as single-cycle strobes from the SD clock generator.

Parameters:
TIMEOUT_CYCLES, 64, SD clock rising edges to wait for a response start bit before flagging timeout
NCC_CYCLES, 8, SD clock rising edges of idle CMD (high) enforced after each command/response

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_sd_clk_rising  in  1  strobe: SD clock rising edge, sample CMD
i_sd_clk_falling  in  1  strobe: SD clock falling edge, drive CMD
o_sd_cmd_oe  out  1  CMD output enable
o_sd_cmd_out  out  1  CMD output value
i_sd_cmd_in  in  1  CMD input, pre-synchronised
i_command_index  in  6  command index to send
i_command_argument  in  32  command argument
i_command_long_response  in  1  expect 136-bit response
i_command_skip_response  in  1  send only, no response phase
i_command_start  in  1  single-cycle start pulse
o_command_index  out  6  received response index field
o_command_response  out  32  last 32 received bits before CRC7+end bit
o_command_busy  out  1  engine active
o_command_timeout  out  1  no start bit within TIMEOUT_CYCLES
o_command_response_crc_error  out  1  received CRC7 mismatch, or missing end bit

Behaviour:
- Reset: state IDLE; o_sd_cmd_oe=0; o_sd_cmd_out=1; o_command_index=0; o_command_response=0; busy, timeout and crc_error all 0. Reset mid-operation aborts immediately; no partial frame continues.
- IDLE, i_command_start=1: latch all inputs. Clear timeout and crc_error. o_command_busy=1 on the next cycle. Go to TX. A start pulse while busy is ignored.
- TX frame, 48 bits MSB-first: '0', '1', index[5:0], argument[31:0], CRC7[6:0], '1'.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
  - Each bit is driven on i_sd_clk_falling with oe=1.
  - The falling edge after bit 0 sets oe=0 and out=1.
  - Next state: skip_response ? NCC : WAIT_START.
- WAIT_START: count i_sd_clk_rising edges. If CMD=0 is sampled, go to RX; that start bit is bit 1 of the frame. If the count reaches TIMEOUT_CYCLES, set timeout=1 and go to NCC.
- RX: sample on each rising strobe until 48 bits (short) or 136 bits (long) are received. 8-bit counter.
  - Short CRC window: frame bits [47:8].
  - Long CRC window: frame bits [127:8]; the first 8 bits are excluded.
  - At frame end:
    - o_command_index = frame bits [45:40] (short) or [133:128] (long).
    - o_command_response = frame bits [39:8].
    - crc_error = (received CRC7 != computed) OR (end bit == 0).
    - Go to NCC.
- NCC: CMD released. After NCC_CYCLES rising strobes go to IDLE; busy=0 in the same cycle. Status outputs hold until the next start.
- Simultaneous rising and falling strobes are illegal; rising takes precedence.
- R3 responses (CRC field all ones) report crc_error; software ignores it for such commands.

Optional Feature:
SD_CMD_INDEX_CHECK_EN
- Defined: for short responses, crc_error is also set when the received index != the sent index.
- Undefined: index is reported only, never checked. The comparator and the latched sent index are compiled out.

Decomposition:
- Shared package sd_pkg:
  - state enum (IDLE, TX, WAIT_START, RX, NCC)
  - frame-length constants (48, 136)
  - CRC7 polynomial constant
- One sub-module: sd_crc_7. Serial CRC7 with clear, enable, data-in and 7-bit crc out. One instance is shared by TX and RX, cleared at each frame start.

Test Plan:
- CMD0, arg 0x00000000, skip_response=1: CMD carries 0x400000000095. busy stays high for exactly 48+8 SD clocks plus pipeline latency; timeout=0 and crc_error=0.
- CMD8, arg 0x000001AA: CMD carries 0x48000001AA87. Card model answers 0x08000001AA13. Expect o_command_index=8, o_command_response=0x000001AA, crc_error=0, timeout=0.
- CMD2, long_response=1: model returns 136 bits with a valid CRC7 in [7:1]. Expect crc_error=0 and index=0x3F. Repeat with a single bit flipped in the CID: crc_error=1.
- CMD55 with CMD held high: timeout=1 exactly 64 rising strobes after the TX end bit. busy drops after a further 8 strobes. Response and index unchanged.
- Second i_command_start pulsed mid-TX: frame is unchanged and no second frame follows. i_reset asserted mid-RX: next cycle oe=0, out=1, busy=0, all status cleared.
- SD_CMD_INDEX_CHECK_EN: CMD17 answered with index 18 and valid CRC: crc_error=1 with the macro defined, 0 without.
